// File: rtl/capture_sequencer.sv
// Ping-pong capture sequencer: decimates ADC strobes into two frame buffers and hands full ones to a stream engine.
// Optional feature: define CAPSEQ_OVF_COUNT_EN to add the saturating ovf_cnt dropped-sample counter.
module capture_sequencer #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DECIM_W = 16
) (
  input  logic               m_axis_aclk,
  input  logic               m_axis_areset,
  input  logic               cfg_enable,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic [ADDR_W-1:0]  cfg_frame_len,
  input  logic               chan1_rdy,
  output logic               wr_en,
  output logic               wr_buf,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               drain_req,
  output logic               drain_buf,
  output logic [ADDR_W-1:0]  drain_len,
  input  logic               drain_ack,
  input  logic               drain_done,
  input  logic               ovf_clr,
  output logic               overflow,
  output logic [31:0]        frame_cnt,
  output logic               busy
`ifdef CAPSEQ_OVF_COUNT_EN
  , output logic [15:0]      ovf_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, SWAP} state_t;

  state_t                   state_q, state_d;
  logic                     wr_en_q, wr_en_d;
  logic                     fill_buf_q, fill_buf_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [1:0][ADDR_W-1:0]   len_q, len_d;
  logic [1:0]               full_q, full_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [DECIM_W-1:0]       decim_cnt_q, decim_cnt_d;
  logic                     overflow_q, overflow_d;
  logic [31:0]              frame_cnt_q, frame_cnt_d;
  logic                     drain_req_q, drain_req_d;
  logic                     drain_buf_q, drain_buf_d;
  logic [ADDR_W-1:0]        drain_len_q, drain_len_d;
  logic                     drain_act_q, drain_act_d;
  logic                     busy_q, busy_d;
`ifdef CAPSEQ_OVF_COUNT_EN
  logic [15:0]              ovf_cnt_q, ovf_cnt_d;
`endif

  logic                     accept, drop, wr_go, done_ok;
  logic                     tgt_buf;
  logic [ADDR_W-1:0]        tgt_addr, tgt_len;

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    fill_buf_d  = fill_buf_q;
    // wr_addr_q shows the address of the write in progress; it advances the cycle after a write
    wr_addr_d   = wr_en_q ? wr_addr_q + 1'b1 : wr_addr_q;
    len_d       = len_q;
    full_d      = full_q;
    rd_ptr_d    = rd_ptr_q;
    decim_cnt_d = decim_cnt_q;
    overflow_d  = ovf_clr ? 1'b0 : overflow_q;
    frame_cnt_d = frame_cnt_q;
    drain_req_d = drain_req_q;
    drain_buf_d = drain_buf_q;
    drain_len_d = drain_len_q;
    drain_act_d = drain_act_q;
`ifdef CAPSEQ_OVF_COUNT_EN
    ovf_cnt_d   = ovf_clr ? 16'd0 : ovf_cnt_q;
`endif
    accept   = 1'b0;
    drop     = 1'b0;
    wr_go    = 1'b0;
    tgt_buf  = fill_buf_q;
    tgt_addr = '0;
    tgt_len  = '0;

    done_ok = drain_done && drain_act_q;
    if (drain_req_q && (drain_ack || done_ok))
      drain_req_d = 1'b0;
    if (done_ok) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
      drain_act_d      = 1'b0;
    end else if (!drain_act_q && full_q[rd_ptr_q]) begin
      drain_req_d = 1'b1;
      drain_act_d = 1'b1;
      drain_buf_d = rd_ptr_q;
      drain_len_d = len_q[rd_ptr_q];
    end

    if (state_q != IDLE && chan1_rdy) begin
      if (decim_cnt_q == cfg_decim) begin
        accept      = 1'b1;
        decim_cnt_d = '0;
      end else begin
        decim_cnt_d = decim_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        wr_addr_d = wr_addr_q;
        if (cfg_enable) begin
          len_d[fill_buf_q] = cfg_frame_len;
          decim_cnt_d       = '0;
          wr_addr_d         = '0;
          state_d           = FILL;
        end
      end
      FILL: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if (accept) begin
          wr_go    = 1'b1;
          tgt_buf  = fill_buf_q;
          tgt_addr = wr_addr_d;
          tgt_len  = len_q[fill_buf_q];
        end
      end
      default: begin
        wr_addr_d = wr_addr_q;
        if (!cfg_enable) begin
          state_d = IDLE;
        // full_d already reflects a drain_done this cycle, so a freed buffer unblocks immediately
        end else if (!full_d[~fill_buf_q]) begin
          fill_buf_d          = ~fill_buf_q;
          len_d[~fill_buf_q]  = cfg_frame_len;
          wr_addr_d           = '0;
          state_d             = FILL;
          if (accept) begin
            wr_go    = 1'b1;
            tgt_buf  = ~fill_buf_q;
            tgt_addr = '0;
            tgt_len  = cfg_frame_len;
          end
        end else if (accept) begin
          drop = 1'b1;
        end
      end
    endcase

    if (wr_go) begin
      wr_en_d   = 1'b1;
      wr_addr_d = tgt_addr;
      if (tgt_addr == tgt_len) begin
        full_d[tgt_buf] = 1'b1;
        frame_cnt_d     = frame_cnt_q + 32'd1;
        state_d         = SWAP;
      end
    end

    if (drop) begin
      overflow_d = 1'b1;
`ifdef CAPSEQ_OVF_COUNT_EN
      if (ovf_cnt_d != 16'hFFFF)
        ovf_cnt_d = ovf_cnt_d + 16'd1;
`endif
    end

    busy_d = (state_d != IDLE) || (|full_d);
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      fill_buf_q  <= 1'b0;
      wr_addr_q   <= '0;
      len_q       <= '0;
      full_q      <= '0;
      rd_ptr_q    <= 1'b0;
      decim_cnt_q <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
      drain_req_q <= 1'b0;
      drain_buf_q <= 1'b0;
      drain_len_q <= '0;
      drain_act_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CAPSEQ_OVF_COUNT_EN
      ovf_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      fill_buf_q  <= fill_buf_d;
      wr_addr_q   <= wr_addr_d;
      len_q       <= len_d;
      full_q      <= full_d;
      rd_ptr_q    <= rd_ptr_d;
      decim_cnt_q <= decim_cnt_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
      drain_req_q <= drain_req_d;
      drain_buf_q <= drain_buf_d;
      drain_len_q <= drain_len_d;
      drain_act_q <= drain_act_d;
      busy_q      <= busy_d;
`ifdef CAPSEQ_OVF_COUNT_EN
      ovf_cnt_q   <= ovf_cnt_d;
`endif
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_buf    = fill_buf_q;
  assign wr_addr   = wr_addr_q;
  assign drain_req = drain_req_q;
  assign drain_buf = drain_buf_q;
  assign drain_len = drain_len_q;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = busy_q;
`ifdef CAPSEQ_OVF_COUNT_EN
  assign ovf_cnt   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: frame fill, decimation, overflow, same-cycle unblock, disable and async reset.
// Exercises ovf_cnt when CAPSEQ_OVF_COUNT_EN is defined.
module tb_capture_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_decim = '0;
  logic [9:0]  cfg_frame_len = '0;
  logic        chan1_rdy = 1'b0;
  logic        wr_en, wr_buf, drain_req, drain_buf, overflow, busy;
  logic [9:0]  wr_addr, drain_len;
  logic        drain_ack = 1'b0;
  logic        drain_done = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] frame_cnt;
`ifdef CAPSEQ_OVF_COUNT_EN
  logic [15:0] ovf_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  capture_sequencer #(.ADDR_W(10), .DECIM_W(16)) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .cfg_enable    (cfg_enable),
    .cfg_decim     (cfg_decim),
    .cfg_frame_len (cfg_frame_len),
    .chan1_rdy     (chan1_rdy),
    .wr_en         (wr_en),
    .wr_buf        (wr_buf),
    .wr_addr       (wr_addr),
    .drain_req     (drain_req),
    .drain_buf     (drain_buf),
    .drain_len     (drain_len),
    .drain_ack     (drain_ack),
    .drain_done    (drain_done),
    .ovf_clr       (ovf_clr),
    .overflow      (overflow),
    .frame_cnt     (frame_cnt),
    .busy          (busy)
`ifdef CAPSEQ_OVF_COUNT_EN
    , .ovf_cnt     (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_enable = 1'b0; chan1_rdy = 1'b0;
    drain_ack = 1'b0; drain_done = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if ({wr_en, wr_buf, wr_addr} !== 12'd0) begin n_err++; $display("FAIL reset_wr: got %b/%b/%0d want 0/0/0", wr_en, wr_buf, wr_addr); end
    n_cmp++; if ({drain_req, drain_buf, drain_len} !== 12'd0) begin n_err++; $display("FAIL reset_drain: got %b/%b/%0d want 0/0/0", drain_req, drain_buf, drain_len); end
    n_cmp++; if ({overflow, busy, frame_cnt} !== 34'd0) begin n_err++; $display("FAIL reset_status: got ovf=%b busy=%b fc=%0d want 0/0/0", overflow, busy, frame_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    do_reset();
    cfg_frame_len = 10'd3; cfg_decim = 16'd0; cfg_enable = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_fill: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      chan1_rdy = 1'b1;
      tick();
      n_cmp++; if ({wr_en, wr_buf, wr_addr} !== {1'b1, 1'b0, 10'(i)}) begin n_err++; $display("FAIL basic_write[%0d]: got en=%b buf=%b addr=%0d want 1/0/%0d", i, wr_en, wr_buf, wr_addr, i); end
    end
    n_cmp++; if (frame_cnt !== 32'd1) begin n_err++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
    chan1_rdy = 1'b0;
    tick();
    n_cmp++; if ({drain_req, drain_buf, drain_len} !== {1'b1, 1'b0, 10'd3}) begin n_err++; $display("FAIL basic_drain_req: got %b/%b/%0d want 1/0/3", drain_req, drain_buf, drain_len); end
    n_cmp++; if ({wr_en, wr_buf} !== 2'b01) begin n_err++; $display("FAIL basic_swap_buf: got en=%b buf=%b want 0/1", wr_en, wr_buf); end
    tick();
    n_cmp++; if (drain_req !== 1'b1) begin n_err++; $display("FAIL basic_req_hold: got %b want 1", drain_req); end
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0;
    n_cmp++; if (drain_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop: got %b want 0", drain_req); end
    drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
    cfg_enable = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_decim();
    int writes;
    writes = 0;
    do_reset();
    cfg_frame_len = 10'd15; cfg_decim = 16'd2; cfg_enable = 1'b1;
    tick();
    for (int s = 1; s <= 9; s++) begin
      chan1_rdy = 1'b1;
      tick();
      if (wr_en === 1'b1) writes++;
      n_cmp++; if (wr_en !== ((s % 3) == 0)) begin n_err++; $display("FAIL decim_strobe[%0d]: got wr_en=%b want %b", s, wr_en, (s % 3) == 0); end
      if ((s % 3) == 0) begin
        n_cmp++; if (wr_addr !== 10'(s / 3 - 1)) begin n_err++; $display("FAIL decim_addr[%0d]: got %0d want %0d", s, wr_addr, s / 3 - 1); end
      end
    end
    chan1_rdy = 1'b0;
    tick();
    n_cmp++; if (writes !== 3) begin n_err++; $display("FAIL decim_count: got %0d want 3", writes); end
    cfg_enable = 1'b0; cfg_decim = 16'd0;
  endtask

  // Fills buf0 and buf1 with 2-sample frames and leaves the FSM blocked in SWAP.
  task automatic fill_two_frames();
    do_reset();
    cfg_frame_len = 10'd1; cfg_decim = 16'd0; cfg_enable = 1'b1;
    tick();
    chan1_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_overflow();
    fill_two_frames();
    tick();
    n_cmp++; if ({wr_en, overflow} !== 2'b01) begin n_err++; $display("FAIL ovf_drop: got wr_en=%b ovf=%b want 0/1", wr_en, overflow); end
    n_cmp++; if (frame_cnt !== 32'd2) begin n_err++; $display("FAIL ovf_frame_cnt: got %0d want 2", frame_cnt); end
    n_cmp++; if ({drain_req, drain_buf} !== 2'b10) begin n_err++; $display("FAIL ovf_drain_first: got req=%b buf=%b want 1/0", drain_req, drain_buf); end
`ifdef CAPSEQ_OVF_COUNT_EN
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (ovf_cnt !== 16'd5) begin n_err++; $display("FAIL ovf_cnt_5: got %0d want 5", ovf_cnt); end
    chan1_rdy = 1'b0; ovf_clr = 1'b1;
    tick();
    n_cmp++; if ({ovf_cnt, overflow} !== 17'd0) begin n_err++; $display("FAIL ovf_cnt_clr: got cnt=%0d ovf=%b want 0/0", ovf_cnt, overflow); end
`endif
    chan1_rdy = 1'b1; ovf_clr = 1'b1;
    tick();
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    chan1_rdy = 1'b0;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0;
    n_cmp++; if (drain_req !== 1'b0) begin n_err++; $display("FAIL ovf_ack: got %b want 0", drain_req); end
    drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
    n_cmp++; if ({wr_en, wr_buf} !== 2'b00) begin n_err++; $display("FAIL ovf_unblock_buf: got en=%b buf=%b want 0/0", wr_en, wr_buf); end
    chan1_rdy = 1'b1;
    tick();
    chan1_rdy = 1'b0;
    n_cmp++; if ({wr_en, wr_buf, wr_addr} !== {1'b1, 1'b0, 10'd0}) begin n_err++; $display("FAIL ovf_next_frame: got %b/%b/%0d want 1/0/0", wr_en, wr_buf, wr_addr); end
    n_cmp++; if ({drain_req, drain_buf, drain_len} !== {1'b1, 1'b1, 10'd1}) begin n_err++; $display("FAIL ovf_drain_second: got %b/%b/%0d want 1/1/1", drain_req, drain_buf, drain_len); end
    cfg_enable = 1'b0;
  endtask

  task automatic test_unblock_same_cycle();
    fill_two_frames();
    chan1_rdy = 1'b0; drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0;
    drain_done = 1'b1; chan1_rdy = 1'b1;
    tick();
    drain_done = 1'b0; chan1_rdy = 1'b0;
    n_cmp++; if ({wr_en, wr_buf, wr_addr} !== {1'b1, 1'b0, 10'd0}) begin n_err++; $display("FAIL same_cycle_write: got %b/%b/%0d want 1/0/0", wr_en, wr_buf, wr_addr); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL same_cycle_ovf: got %b want 0", overflow); end
    cfg_enable = 1'b0;
  endtask

  task automatic test_disable();
    do_reset();
    cfg_frame_len = 10'd1; cfg_decim = 16'd0; cfg_enable = 1'b1;
    tick();
    chan1_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chan1_rdy = 1'b0; cfg_enable = 1'b0;
    tick();
    n_cmp++; if ({busy, drain_req, wr_en} !== 3'b110) begin n_err++; $display("FAIL disable_idle: got busy=%b req=%b wr_en=%b want 1/1/0", busy, drain_req, wr_en); end
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0; drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
    tick();
    n_cmp++; if ({busy, frame_cnt} !== {1'b0, 32'd1}) begin n_err++; $display("FAIL disable_drained: got busy=%b fc=%0d want 0/1", busy, frame_cnt); end
  endtask

  task automatic test_reset_midframe();
    logic seen;
    seen = 1'b0;
    do_reset();
    cfg_frame_len = 10'd3; cfg_decim = 16'd0; cfg_enable = 1'b1;
    tick();
    chan1_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chan1_rdy = 1'b0;
    n_cmp++; if ({wr_en, wr_addr} !== {1'b1, 10'd2}) begin n_err++; $display("FAIL midrst_pre: got en=%b addr=%0d want 1/2", wr_en, wr_addr); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({wr_en, wr_buf, wr_addr, busy} !== 13'd0) begin n_err++; $display("FAIL midrst_async_wr: got en=%b buf=%b addr=%0d busy=%b want 0", wr_en, wr_buf, wr_addr, busy); end
    n_cmp++; if ({drain_req, drain_buf, drain_len, overflow, frame_cnt} !== 45'd0) begin n_err++; $display("FAIL midrst_async_status: got req=%b len=%0d ovf=%b fc=%0d want 0", drain_req, drain_len, overflow, frame_cnt); end
    cfg_enable = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr_en !== 1'b0 || drain_req !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_quiet: got activity=%b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_decim();
    test_overflow();
    test_unblock_same_cycle();
    test_disable();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
